// File: rtl/bpsk_tx_modulator.sv
`timescale 1ns/1ps
// bpsk_tx_modulator: frame transmitter feeding an 8-bit DAC.
// A frame is a calibration burst, then an idle gap, then the payload bytes
// sent LSB first as 3-sample-carrier BPSK.
// Optional feature: define TX_CRC8_EN to append a CRC-8 byte after the payload.
module bpsk_tx_modulator #(
    parameter int         SAMPLES_PER_BIT = 45,
    parameter int         CAL_SAMPLES     = 45,
    parameter int         GAP_SAMPLES     = 270,
    parameter int         FRAME_BYTES     = 6,
    parameter logic [7:0] IDLE_LEVEL      = 8'h7f
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       tx_start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] da,
    output logic       sync_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int CNT_MAX = (CAL_SAMPLES > GAP_SAMPLES) ? CAL_SAMPLES : GAP_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SPB_W   = $clog2(SAMPLES_PER_BIT + 1);
    localparam int BYTE_W  = $clog2(FRAME_BYTES + 1);

    localparam logic [CNT_W-1:0]  CAL_LAST  = CNT_W'(CAL_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_SAMPLES - 1);
    localparam logic [SPB_W-1:0]  SPB_LAST  = SPB_W'(SAMPLES_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAME_BYTES - 1);

    localparam logic [7:0] SYM_MID = 8'h7f;
    localparam logic [7:0] SYM_HI  = 8'h93;
    localparam logic [7:0] SYM_LO  = 8'h6d;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAL,
        ST_GAP,
        ST_DATA
`ifdef TX_CRC8_EN
        , ST_CRC
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         phase_q, phase_d;
    logic [SPB_W-1:0]   spb_q, spb_d;
    logic [2:0]         bit_q, bit_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic [7:0]         shift_q, shift_d;
    logic               underrun_q, underrun_d;
    logic [7:0]         da_q, da_d;
    logic               sync_q, sync_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef TX_CRC8_EN
    logic [7:0]         crc_q, crc_d;
`endif

    logic       fetch;
    logic [7:0] fetched;
    logic [1:0] phase_inc;
    logic       bit_end;

    // Carrier sample for one bit at carrier phase p; bit 0 is the inverted carrier.
    function automatic logic [7:0] carrier(input logic bit_val, input logic [1:0] p);
        case (p)
            2'd1:    return bit_val ? SYM_HI : SYM_LO;
            2'd2:    return bit_val ? SYM_LO : SYM_HI;
            default: return SYM_MID;
        endcase
    endfunction

`ifdef TX_CRC8_EN
    // One byte of CRC-8 (poly 0x07), processed MSB first.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    // Next-state logic: sequencing, byte fetch, and the sample to present next cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        spb_d      = spb_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        underrun_d = underrun_q;
`ifdef TX_CRC8_EN
        crc_d      = crc_q;
`endif

        fetch     = ((state_q == ST_GAP) && (cnt_q == GAP_LAST)) ||
                    ((state_q == ST_DATA) && (bit_q == 3'd7) && (spb_q == SPB_LAST) &&
                     (byte_q != BYTE_LAST));
        in_ready  = fetch;
        fetched   = (fetch && in_valid) ? in_data : 8'h00;
        phase_inc = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        bit_end   = (spb_q == SPB_LAST);

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d    = ST_CAL;
                    cnt_d      = '0;
                    phase_d    = 2'd0;
                    underrun_d = 1'b0;
`ifdef TX_CRC8_EN
                    crc_d      = 8'h00;
`endif
                end
            end
            ST_CAL: begin
                phase_d = phase_inc;
                if (cnt_q == CAL_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_DATA;
                    phase_d = 2'd0;
                    spb_d   = '0;
                    bit_d   = 3'd0;
                    byte_d  = '0;
                    shift_d = fetched;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                phase_d = phase_inc;
                if (!bit_end) begin
                    spb_d = spb_q + 1'b1;
                end else begin
                    spb_d = '0;
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end else begin
                        bit_d = 3'd0;
                        if (byte_q == BYTE_LAST) begin
`ifdef TX_CRC8_EN
                            state_d = ST_CRC;
                            shift_d = crc_q;
`else
                            state_d = ST_IDLE;
`endif
                        end else begin
                            byte_d  = byte_q + 1'b1;
                            shift_d = fetched;
                        end
                    end
                end
            end
`ifdef TX_CRC8_EN
            ST_CRC: begin
                phase_d = phase_inc;
                if (!bit_end) begin
                    spb_d = spb_q + 1'b1;
                end else begin
                    spb_d = '0;
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end else begin
                        bit_d   = 3'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (fetch && !in_valid) begin
            underrun_d = 1'b1;
        end
`ifdef TX_CRC8_EN
        if (fetch) begin
            crc_d = crc8_next(crc_q, fetched);
        end
`endif

        case (state_d)
            ST_CAL:  da_d = carrier(1'b1, phase_d);
            ST_DATA: da_d = carrier(shift_d[0], phase_d);
`ifdef TX_CRC8_EN
            ST_CRC:  da_d = carrier(shift_d[0], phase_d);
`endif
            default: da_d = IDLE_LEVEL;
        endcase

`ifdef TX_CRC8_EN
        sync_d = (state_d == ST_DATA) || (state_d == ST_CRC);
        done_d = (state_d == ST_CRC) && (bit_d == 3'd7) && (spb_d == SPB_LAST);
`else
        sync_d = (state_d == ST_DATA);
        done_d = (state_d == ST_DATA) && (byte_d == BYTE_LAST) &&
                 (bit_d == 3'd7) && (spb_d == SPB_LAST);
`endif
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops straight back to idle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            phase_q    <= 2'd0;
            spb_q      <= '0;
            bit_q      <= 3'd0;
            byte_q     <= '0;
            shift_q    <= 8'h00;
            underrun_q <= 1'b0;
            da_q       <= IDLE_LEVEL;
            sync_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TX_CRC8_EN
            crc_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            spb_q      <= spb_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            underrun_q <= underrun_d;
            da_q       <= da_d;
            sync_q     <= sync_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef TX_CRC8_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign da       = da_q;
    assign sync_out = sync_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_bpsk_tx_modulator.sv
`timescale 1ns/1ps
// Scoreboard bench for bpsk_tx_modulator: every frame is expanded by a
// reference model into its full DAC sample sequence, and a monitor checks
// the DUT against that sequence sample by sample.
module tb_bpsk_tx_modulator;

   localparam int SPB = 45;
   localparam int CAL = 45;
   localparam int GAP = 270;
   localparam int NB  = 6;
`ifdef TX_CRC8_EN
   localparam int TOTB = NB + 1;
`else
   localparam int TOTB = NB;
`endif
   localparam int DATA_LEN  = 8 * SPB * TOTB;
   localparam int FRAME_LEN = CAL + GAP + DATA_LEN;
`ifdef TX_CRC8_EN
   localparam int RESET_AT = CAL + GAP + 8 * SPB * NB + 100;
`else
   localparam int RESET_AT = CAL + GAP + 1000;
`endif

   logic       clock;
   logic       resetN;
   logic       tx_start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] da;
   logic       sync_out;
   logic       busy;
   logic       done;
   logic       underrun;

   typedef struct packed {
      logic [7:0] da;
      logic       sync;
      logic       done;
   } sample_t;

   typedef struct packed {
      logic [7:0] data;
      logic       drop;
   } fetch_t;

   sample_t    expQ[$];
   fetch_t     fetchQ[$];
   int         errors = 0;
   int         checks = 0;
   int         fetchCount = 0;
   int         fetchBase = 0;
   logic       expUnderrun = 1'b0;
   logic [7:0] frameBytes [NB];
   logic       frameDrop  [NB];
   logic [7:0] sentBytes  [TOTB];

   bpsk_tx_modulator #(
      .SAMPLES_PER_BIT(SPB),
      .CAL_SAMPLES    (CAL),
      .GAP_SAMPLES    (GAP),
      .FRAME_BYTES    (NB),
      .IDLE_LEVEL     (8'h7f)
   ) dut (
      .clock   (clock),
      .resetN  (resetN),
      .tx_start(tx_start),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .da      (da),
      .sync_out(sync_out),
      .busy    (busy),
      .done    (done),
      .underrun(underrun)
   );

   // Free-running sample clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Carrier sample for a bit at carrier phase p.
   function automatic logic [7:0] carrierLevel(input logic bitVal, input int p);
      if (p == 0) return 8'h7f;
      if (bitVal) return (p == 1) ? 8'h93 : 8'h6d;
      return (p == 1) ? 8'h6d : 8'h93;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Expands the current frame into the expected DAC sequence and issues tx_start.
   task automatic applyStimulus();
      int byteIdx;
      int bitIdx;
      logic bitVal;
      expUnderrun = 1'b0;
      for (int i = 0; i < NB; i++) begin
         sentBytes[i] = frameDrop[i] ? 8'h00 : frameBytes[i];
         if (frameDrop[i]) expUnderrun = 1'b1;
         fetchQ.push_back('{data: frameBytes[i], drop: frameDrop[i]});
      end
`ifdef TX_CRC8_EN
      begin
         logic [8*NB+7:0] m;
         m = '0;
         for (int i = 0; i < NB; i++) m[8*NB+7-8*i -: 8] = sentBytes[i];
         for (int k = 8*NB+7; k >= 8; k--) begin
            if (m[k]) m[k -: 9] = m[k -: 9] ^ 9'h107;
         end
         sentBytes[NB] = m[7:0];
      end
`endif
      for (int i = 0; i < CAL; i++)
         expQ.push_back('{da: carrierLevel(1'b1, i % 3), sync: 1'b0, done: 1'b0});
      for (int i = 0; i < GAP; i++)
         expQ.push_back('{da: 8'h7f, sync: 1'b0, done: 1'b0});
      for (int s = 0; s < DATA_LEN; s++) begin
         byteIdx = s / (8 * SPB);
         bitIdx  = (s / SPB) % 8;
         bitVal  = sentBytes[byteIdx][bitIdx];
         expQ.push_back('{da: carrierLevel(bitVal, s % 3), sync: 1'b1,
                          done: (s == DATA_LEN - 1)});
      end
      fetchBase = fetchCount;
      tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0;
      checkOutput("underrun cleared", {31'd0, underrun}, 32'd0);
      checkOutput("busy rise", {31'd0, busy}, 32'd1);
   endtask

   task automatic waitFrameEnd();
      int cycles;
      cycles = 0;
      while ((busy || expQ.size() != 0) && cycles < FRAME_LEN + 50) begin
         @(negedge clock);
         cycles++;
      end
      checkOutput("busy at end", {31'd0, busy}, 32'd0);
      checkOutput("samples left", expQ.size(), 32'd0);
      expQ.delete();
      checkOutput("fetch count", fetchCount - fetchBase, NB);
      checkOutput("underrun flag", {31'd0, underrun}, {31'd0, expUnderrun});
      fetchQ.delete();
   endtask

   task automatic randomFrame(input bit withDrops);
      for (int i = 0; i < NB; i++) begin
         frameBytes[i] = 8'($urandom);
         frameDrop[i]  = withDrops && ($urandom_range(0, 7) == 0);
      end
   endtask

   // Byte source: serves frame bytes at fetch points, offers junk elsewhere.
   initial begin
      fetch_t f;
      in_valid = 1'b0;
      in_data  = 8'h00;
      forever begin
         @(negedge clock);
         if (in_ready === 1'b1) begin
            fetchCount++;
            if (fetchQ.size() > 0) begin
               f        = fetchQ.pop_front();
               in_data  = f.data;
               in_valid = !f.drop;
            end else begin
               in_data  = 8'($urandom);
               in_valid = 1'b0;
            end
         end else begin
            in_data  = 8'($urandom);
            in_valid = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: every busy cycle consumes one expected sample; idle cycles must rest at mid-scale.
   initial begin
      sample_t expSample;
      forever begin
         @(negedge clock);
         if (resetN === 1'b1) begin
            if (busy === 1'b1) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected sample: got da=%0h sync=%0b done=%0b expected no frame at %0t",
                           da, sync_out, done, $time);
               end else begin
                  expSample = expQ.pop_front();
                  checkOutput("dac sample", {22'd0, da, sync_out, done}, {22'd0, expSample});
               end
            end else begin
               checkOutput("idle outputs", {21'd0, da, sync_out, done, in_ready},
                           {21'd0, 8'h7f, 3'b000});
            end
         end
      end
   end

   // Guard against a hung run.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Test sequence: reset, directed frames, collisions, random frames, mid-frame reset.
   initial begin
      resetN   = 1'b0;
      tx_start = 1'b0;
      repeat (10) begin
         @(negedge clock);
         checkOutput("reset outputs", {18'd0, da, sync_out, busy, in_ready, done, underrun},
                     {18'd0, 8'h7f, 5'b00000});
      end
      #2 resetN = 1'b1;
      repeat (5) @(negedge clock);

      $display("[TB] directed payload frame");
      frameBytes = '{8'hff, 8'h00, 8'h55, 8'haa, 8'hf0, 8'h0f};
      frameDrop  = '{default: 1'b0};
      applyStimulus();
      waitFrameEnd();

      $display("[TB] underrun at third fetch");
      randomFrame(1'b0);
      frameDrop[2] = 1'b1;
      applyStimulus();
      waitFrameEnd();
      repeat (7) @(negedge clock);
      checkOutput("underrun sticky", {31'd0, underrun}, 32'd1);

      $display("[TB] start collisions");
      frameBytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      frameDrop  = '{default: 1'b0};
      applyStimulus();
      repeat (CAL + 10) @(negedge clock);
      tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0;
      repeat (FRAME_LEN - 1 - (CAL + 11)) @(negedge clock);
      checkOutput("done cycle", {31'd0, done}, 32'd1);
      tx_start = 1'b1;
      @(negedge clock);
      checkOutput("busy after done", {31'd0, busy}, 32'd0);
      checkOutput("collision fetches", fetchCount - fetchBase, NB);
      checkOutput("collision samples left", expQ.size(), 32'd0);
      expQ.delete();
      fetchQ.delete();
      randomFrame(1'b1);
      applyStimulus();
      waitFrameEnd();

      $display("[TB] random frames");
      for (int f = 0; f < 3; f++) begin
         repeat ($urandom_range(1, 20)) @(negedge clock);
         randomFrame(1'b1);
         applyStimulus();
         waitFrameEnd();
      end

      $display("[TB] reset mid-frame");
      randomFrame(1'b0);
      frameDrop[0] = 1'b1;
      applyStimulus();
      repeat (RESET_AT) @(negedge clock);
      #2 resetN = 1'b0;
      #1;
      checkOutput("async reset", {18'd0, da, sync_out, busy, in_ready, done, underrun},
                  {18'd0, 8'h7f, 5'b00000});
      expQ.delete();
      fetchQ.delete();
      repeat (3) @(negedge clock);
      #2 resetN = 1'b1;
      @(negedge clock);

      $display("[TB] frame after reset");
      randomFrame(1'b0);
      applyStimulus();
      waitFrameEnd();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
